// File: rtl/ahb_sram_pkg.sv
// ahb_sram_pkg: shared constants, FSM state type and helpers for the AHB-Lite
// SRAM responder (ahb_sram_slave) and its RAM macro (ahb_sram_mem).
//   - HTRANS / HSIZE encodings
//   - state_e   : data-phase FSM states
//   - trans_active()  : NONSEQ/SEQ detect
//   - strobe_decode() : little-endian byte-lane strobes from HSIZE/HADDR[1:0]
package ahb_sram_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned BYTES  = DATA_W / 8;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_BUSY   = 2'b01;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
   localparam logic [1:0] HTRANS_SEQ    = 2'b11;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   // ST_ERR1/ST_ERR2 are only reachable when AHB_SRAM_ERR_EN is defined
   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_RD   = 3'd1,
      ST_WR   = 3'd2,
      ST_ERR1 = 3'd3,
      ST_ERR2 = 3'd4
   } state_e;

   // Only NONSEQ and SEQ start a transfer
   function automatic logic trans_active(input logic [1:0] trans);
      logic act;
      case (trans)
         HTRANS_IDLE, HTRANS_BUSY:  act = 1'b0;
         HTRANS_NONSEQ, HTRANS_SEQ: act = 1'b1;
         default:                   act = 1'b0;
      endcase
      return act;
   endfunction

   // Address bits below the transfer size are ignored; sizes above a word
   // collapse to a full-word access
   function automatic logic [BYTES-1:0] strobe_decode(input logic [2:0] size,
                                                      input logic [1:0] addr_lo);
      logic [BYTES-1:0] strb;
      case (size)
         HSIZE_BYTE: strb = 4'b0001 << addr_lo;
         HSIZE_HALF: strb = addr_lo[1] ? 4'b1100 : 4'b0011;
         HSIZE_WORD: strb = 4'b1111;
         default:    strb = 4'b1111;
      endcase
      return strb;
   endfunction

endpackage

// File: rtl/ahb_sram_mem.sv
// ahb_sram_mem: inferred simple dual-port block RAM, MEM_WORDS x 32.
// One synchronous read port and one byte-enabled write port on the same
// clock; a same-address read and write on one edge returns the old word.
// Ports:
//   clk_i    clock
//   we_i     write enable, wa_i word index, wstrb_i byte lanes, wdata_i data
//   re_i     read enable,  ra_i word index, rdata_o registered read data
// Contents are not reset.
module ahb_sram_mem
   import ahb_sram_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 16384,
   parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
   input  logic              clk_i,
   input  logic              we_i,
   input  logic [AW-1:0]     wa_i,
   input  logic [BYTES-1:0]  wstrb_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic              re_i,
   input  logic [AW-1:0]     ra_i,
   output logic [DATA_W-1:0] rdata_o
);

   logic [DATA_W-1:0] mem_q [MEM_WORDS];
   logic [DATA_W-1:0] rdata_q;

   // Read-before-write storage array
   always_ff @(posedge clk_i) begin
      if (re_i) begin
         rdata_q <= mem_q[ra_i];
      end
      for (int unsigned b = 0; b < BYTES; b++) begin
         if (we_i && wstrb_i[b]) begin
            mem_q[wa_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: zero-wait-state AHB-Lite responder in front of on-chip RAM.
// Byte/halfword/word transfers, little-endian lanes, write-to-read forwarding
// for a read issued in the cycle after a write to the same word.
// Optional feature macro: AHB_SRAM_ERR_EN -- out-of-range addresses and
// HSIZE > word get a two-cycle ERROR response. Without it HRESP is 0, the
// index wraps modulo MEM_WORDS and oversize transfers act as word accesses.
// Ports:
//   HCLK, HRESET          clock, synchronous active-high reset
//   HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT   address phase
//   HWDATA                write data (data phase)
//   HREADY                global ready from the HREADY mux
//   HREADYOUT, HRDATA, HRESP   slave response
module ahb_sram_slave
   import ahb_sram_pkg::*;
#(
   parameter int unsigned MEM_WORDS = 16384,
   parameter int unsigned AW        = $clog2(MEM_WORDS)
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic [3:0]  HPROT,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic [31:0] HRDATA,
   output logic        HRESP
);

   state_e            state_q;
   logic              hreadyout_q;
   logic [31:0]       hold_q;
   logic              fwd_vld_q;
   logic [31:0]       fwd_data_q;
   logic [BYTES-1:0]  fwd_strb_q;
   logic [AW-1:0]     wr_idx_q;
   logic [BYTES-1:0]  wr_strb_q;

   logic              acc_c;
   logic              illegal_c;
   logic              acc_rd_c;
   logic              acc_wr_c;
   logic              mem_we_c;
   logic              hazard_c;
   logic [AW-1:0]     idx_c;
   logic [BYTES-1:0]  strb_c;
   logic [31:0]       ram_rdata;
   logic [31:0]       rd_mux_c;

   logic              unused_ok;
   assign unused_ok = ^{HBURST, HPROT, HADDR};

   assign idx_c  = HADDR[AW+1:2];
   assign strb_c = strobe_decode(HSIZE, HADDR[1:0]);

   // No address phase is taken while the first ERROR cycle is on the bus
   assign acc_c = HSEL & trans_active(HTRANS) & HREADY & (state_q != ST_ERR1);

`ifdef AHB_SRAM_ERR_EN
   logic hresp_q;
   assign illegal_c = ((HADDR >> (AW + 2)) != 32'd0) | (HSIZE > HSIZE_WORD);
   assign HRESP     = hresp_q;
`else
   assign illegal_c = 1'b0;
   assign HRESP     = 1'b0;
`endif

   assign acc_rd_c = acc_c & ~illegal_c & ~HWRITE;
   assign acc_wr_c = acc_c & ~illegal_c &  HWRITE;

   // Write commits at the edge ending its data phase; reset discards it
   assign mem_we_c = (state_q == ST_WR) & HREADY & ~HRESET;

   // Read landing on the word being written this edge: RAM returns old data
   assign hazard_c = acc_rd_c & mem_we_c & (idx_c == wr_idx_q);

   ahb_sram_mem #(
      .MEM_WORDS (MEM_WORDS),
      .AW        (AW)
   ) u_mem (
      .clk_i   (HCLK),
      .we_i    (mem_we_c),
      .wa_i    (wr_idx_q),
      .wstrb_i (wr_strb_q),
      .wdata_i (HWDATA),
      .re_i    (acc_rd_c),
      .ra_i    (idx_c),
      .rdata_o (ram_rdata)
   );

   // Per-lane merge of forwarded write bytes over the RAM word
   always_comb begin
      rd_mux_c = ram_rdata;
      for (int unsigned b = 0; b < BYTES; b++) begin
         if (fwd_vld_q && fwd_strb_q[b]) begin
            rd_mux_c[8*b +: 8] = fwd_data_q[8*b +: 8];
         end
      end
   end

   // Data-phase FSM, response registers, write/forward capture
   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q     <= ST_IDLE;
         hreadyout_q <= 1'b1;
         hold_q      <= 32'd0;
         fwd_vld_q   <= 1'b0;
         fwd_data_q  <= 32'd0;
         fwd_strb_q  <= '0;
         wr_idx_q    <= '0;
         wr_strb_q   <= '0;
`ifdef AHB_SRAM_ERR_EN
         hresp_q     <= 1'b0;
`endif
      end else begin
         // Keeps HRDATA stable once the read data phase is over
         if (state_q == ST_RD) begin
            hold_q <= rd_mux_c;
         end
         if (acc_rd_c) begin
            fwd_vld_q  <= hazard_c;
            fwd_data_q <= HWDATA;
            fwd_strb_q <= wr_strb_q;
         end
         if (acc_wr_c) begin
            wr_idx_q  <= idx_c;
            wr_strb_q <= strb_c;
         end
`ifdef AHB_SRAM_ERR_EN
         if (state_q == ST_ERR1) begin
            state_q     <= ST_ERR2;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b1;
         end else
`endif
         if (HREADY) begin
            hreadyout_q <= 1'b1;
`ifdef AHB_SRAM_ERR_EN
            hresp_q     <= 1'b0;
`endif
            if (acc_rd_c) begin
               state_q <= ST_RD;
            end else if (acc_wr_c) begin
               state_q <= ST_WR;
`ifdef AHB_SRAM_ERR_EN
            end else if (acc_c) begin
               state_q     <= ST_ERR1;
               hreadyout_q <= 1'b0;
               hresp_q     <= 1'b1;
`endif
            end else begin
               state_q <= ST_IDLE;
            end
         end
      end
   end

   assign HREADYOUT = hreadyout_q;
   assign HRDATA    = (state_q == ST_RD) ? rd_mux_c : hold_q;

endmodule
